// File: rtl/ahb_fetch_master.sv
// AHB-Lite read-only fetch initiator: turns core word-fetch requests into pipelined
// single NONSEQ reads and queues the returned words in an in-order response FIFO.
module ahb_fetch_master #(
    parameter int ADDR_W    = 20,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    input  logic              flush,
    output logic              busy,
    output logic              hsel,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [1:0]        hburst,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              addr_pend;
    logic              addr_disc;
    logic              data_pend;
    logic              data_disc;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       fifo_mem [RSP_DEPTH];

    logic [CNT_W:0]    in_flight;
    logic              accept;
    logic              addr_adv;
    logic              data_done;
    logic              push;
    logic              pop;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];

    // Every fetch on the bus already owns a FIFO slot, so the FIFO can never overflow.
    assign in_flight = {{CNT_W{1'b0}}, addr_pend} + {{CNT_W{1'b0}}, data_pend} + {1'b0, cnt};

    assign req_ready = !reset && !flush && (!addr_pend || hready)
                       && (in_flight < (CNT_W + 1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign addr_adv  = addr_pend && hready;
    assign data_done = data_pend && hready;
    assign push      = data_done && !data_disc && !flush;
    assign pop       = rsp_valid && rsp_ready && !flush;

    assign rsp_valid = (cnt != '0);
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : 32'h0;
    assign busy      = addr_pend | data_pend;

    assign hsize  = 3'h2;
    assign hburst = 2'b00;
    assign hwrite = 1'b0;
    assign hwdata = 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsel      <= 1'b0;
            htrans    <= HTRANS_IDLE;
            haddr     <= '0;
            addr_pend <= 1'b0;
            addr_disc <= 1'b0;
            data_pend <= 1'b0;
            data_disc <= 1'b0;
        end else begin
            if (accept) begin
                hsel      <= 1'b1;
                htrans    <= HTRANS_NONSEQ;
                haddr     <= {req_addr[ADDR_W-1:2], 2'b00};
                addr_pend <= 1'b1;
                addr_disc <= 1'b0;
            end else if (addr_adv) begin
                hsel      <= 1'b0;
                htrans    <= HTRANS_IDLE;
                haddr     <= '0;
                addr_pend <= 1'b0;
                addr_disc <= 1'b0;
            end else if (flush && addr_pend) begin
                // A NONSEQ cannot be withdrawn; remember to drop its data instead.
                addr_disc <= 1'b1;
            end

            if (addr_adv) begin
                data_pend <= 1'b1;
                data_disc <= addr_disc || flush;
            end else if (data_done) begin
                data_pend <= 1'b0;
                data_disc <= 1'b0;
            end else if (flush && data_pend) begin
                data_disc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; rsp_data is masked by rsp_valid, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= hrdata;
    end

endmodule

// File: tb/tb_ahb_fetch_master.sv
// Directed bench for ahb_fetch_master with a zero/controllable-wait AHB slave model.
module tb_ahb_fetch_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        flush = 1'b0;
    logic        busy;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [1:0]  hburst;
    logic        hwrite;
    logic [19:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready = 1'b1;

    int errors = 0;
    int checks = 0;

    ahb_fetch_master #(.ADDR_W(20), .RSP_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .flush(flush), .busy(busy),
        .hsel(hsel), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwrite(hwrite),
        .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata), .hready(hready)
    );

    always #5 clk = ~clk;

    // Memory contents seen by the master: a tag plus the word address.
    function automatic logic [31:0] word(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    // Slave: latch the address on an accepted NONSEQ, return its word in the data phase.
    logic [19:0] dp_addr;
    always @(posedge clk or posedge reset) begin
        if (reset) dp_addr <= '0;
        else if (hready && hsel && htrans == 2'b10) dp_addr <= haddr;
    end
    assign hrdata = word(dp_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hsel"}, 32'(hsel), 0);
        check({tag, "_htrans"}, 32'(htrans), 0);
        check({tag, "_haddr"}, 32'(haddr), 0);
        check({tag, "_hsize"}, 32'(hsize), 2);
        check({tag, "_hburst"}, 32'(hburst), 0);
        check({tag, "_hwrite"}, 32'(hwrite), 0);
        check({tag, "_hwdata"}, hwdata, 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] seq [6];
        logic [31:0] got [$];
        int idx;
        int nonseq;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_ready", 32'(req_ready), 1);

        // Single fetch 0x20, zero-wait slave
        req_valid = 1'b1;
        req_addr  = 20'h00020;
        tick();
        req_valid = 1'b0;
        check("single_htrans", 32'(htrans), 2);
        check("single_hsel", 32'(hsel), 1);
        check("single_haddr", 32'(haddr), 32'h20);
        check("single_rsp_e0", 32'(rsp_valid), 0);
        tick();
        check("single_idle_e1", 32'(htrans), 0);
        check("single_busy_e1", 32'(busy), 1);
        check("single_rsp_e1", 32'(rsp_valid), 0);
        tick();
        check("single_rsp_e2", 32'(rsp_valid), 1);
        check("single_data", rsp_data, word(20'h00020));
        check("single_busy_e2", 32'(busy), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("single_popped", 32'(rsp_valid), 0);

        // icache miss: address phase stalled 40 cycles
        req_valid = 1'b1;
        req_addr  = 20'h00030;
        tick();
        req_valid = 1'b0;
        hready    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            req_valid = 1'b1;
            req_addr  = 20'h00040;
            #1;
            check("miss_req_ready", 32'(req_ready), 0);
            tick();
            req_valid = 1'b0;
            check("miss_htrans", 32'(htrans), 2);
            check("miss_haddr", 32'(haddr), 32'h30);
        end
        hready = 1'b1;
        tick();
        check("miss_idle", 32'(htrans), 0);
        check("miss_rsp_early", 32'(rsp_valid), 0);
        tick();
        check("miss_rsp_valid", 32'(rsp_valid), 1);
        check("miss_data", rsp_data, word(20'h00030));
        rsp_ready = 1'b1;
        tick();
        check("miss_single", 32'(rsp_valid), 0);

        // Back-to-back fetches, full throughput
        seq = '{20'h00020, 20'h00024, 20'h00030, 20'h00034, 20'h00020, 20'h00024};
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 6);
            req_addr  = (k < 6) ? seq[k] : 20'h0;
            #1;
            if (k < 6) check("b2b_req_ready", 32'(req_ready), 1);
            tick();
            if (k < 6) begin
                check("b2b_htrans", 32'(htrans), 2);
                check("b2b_haddr", 32'(haddr), 32'(seq[k]));
            end else begin
                check("b2b_idle", 32'(htrans), 0);
            end
            if (k >= 2) begin
                check("b2b_rsp_valid", 32'(rsp_valid), 1);
                check("b2b_data", rsp_data, word(seq[k-2]));
            end
        end
        req_valid = 1'b0;
        tick();
        check("b2b_drained", 32'(rsp_valid), 0);
        check("b2b_busy", 32'(busy), 0);

        // Backpressure: only RSP_DEPTH fetches may be outstanding
        rsp_ready = 1'b0;
        idx       = 0;
        nonseq    = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_addr  = 20'h00100 + 20'(idx * 4);
            #1;
            check("bp_req_ready", 32'(req_ready), (c < 4) ? 1 : 0);
            if (req_ready) idx++;
            tick();
            if (htrans == 2'b10) nonseq++;
        end
        check("bp_nonseq_count", 32'(nonseq), 4);
        check("bp_head_valid", 32'(rsp_valid), 1);
        check("bp_head_data", rsp_data, word(20'h00100));
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            req_valid = (idx < 6);
            req_addr  = 20'h00100 + 20'(idx * 4);
            #1;
            if (c == 0) check("bp_pop_no_credit", 32'(req_ready), 0);
            if (rsp_valid) got.push_back(rsp_data);
            if (req_valid && req_ready) idx++;
            tick();
        end
        req_valid = 1'b0;
        check("bp_rsp_count", 32'(got.size()), 6);
        for (int i = 0; i < 6; i++)
            check("bp_order", (i < got.size()) ? got[i] : 32'hDEAD_DEAD, word(20'h00100 + 20'(i * 4)));
        tick();
        check("bp_idle", 32'(busy), 0);

        // Flush with one queued word, one data phase and one stalled address phase
        rsp_ready = 1'b0;
        seq[0] = 20'h00300;
        seq[1] = 20'h00200;
        seq[2] = 20'h00204;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_addr  = seq[k];
            #1;
            check("fl_req_ready", 32'(req_ready), 1);
            tick();
        end
        req_valid = 1'b0;
        check("fl_queued", 32'(rsp_valid), 1);
        hready = 1'b0;
        flush  = 1'b1;
        #1;
        check("fl_no_accept", 32'(req_ready), 0);
        tick();
        flush = 1'b0;
        check("fl_cleared", 32'(rsp_valid), 0);
        check("fl_addr_held", 32'(haddr), 32'h204);
        check("fl_htrans_held", 32'(htrans), 2);
        check("fl_busy", 32'(busy), 1);
        tick();
        tick();
        check("fl_stall_rsp", 32'(rsp_valid), 0);
        hready = 1'b1;
        tick();
        check("fl_addr_done", 32'(htrans), 0);
        check("fl_discard_a", 32'(rsp_valid), 0);
        tick();
        check("fl_discard_b", 32'(rsp_valid), 0);
        check("fl_busy_done", 32'(busy), 0);
        req_valid = 1'b1;
        req_addr  = 20'h00024;
        tick();
        req_valid = 1'b0;
        tick();
        check("fl_next_early", 32'(rsp_valid), 0);
        tick();
        check("fl_next_valid", 32'(rsp_valid), 1);
        check("fl_next_data", rsp_data, word(20'h00024));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("fl_only_one", 32'(rsp_valid), 0);

        // Unaligned address, then async reset mid data phase
        req_valid = 1'b1;
        req_addr  = 20'h00023;
        tick();
        check("unaligned_haddr", 32'(haddr), 32'h20);
        req_addr = 20'h00044;
        tick();
        req_valid = 1'b0;
        hready    = 1'b0;
        check("rst_pre_htrans", 32'(htrans), 2);
        check("rst_pre_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        reset  = 1'b0;
        hready = 1'b1;
        #1;
        check("midrst_recover", 32'(req_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_fetch_master.md
# ahb_fetch_master

AHB-Lite read-only initiator that turns word-fetch requests from a core-side valid/ready port into single NONSEQ word reads on the instruction-cache AHB slave port (hsel/htrans/hsize/hburst/hwrite/haddr/hwdata in, rdata/hready_out out). It pipelines address and data phases for up to one transfer per cycle, buffers read data in a small response FIFO with backpressure, and supports a flush that discards in-flight fetches. It replaces bench-driven AHB stimulus in front of the icache in the integrated fetch path.

## Interface
- ADDR_W, 20, AHB/fetch address width
- RSP_DEPTH, 4, response FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted at rising edge when both high
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer pops head when both high
- rsp_data  out  32  FIFO head word
- flush  in  1  single-cycle pulse: discard all queued and in-flight fetches
- busy  out  1  addr_pend | data_pend
- hsel  out  1  slave select
- htrans  out  2  IDLE(0) or NONSEQ(2) only
- hsize  out  3  constant 3'h2 (word)
- hburst  out  2  constant 0 (SINGLE)
- hwrite  out  1  constant 0
- haddr  out  ADDR_W  {req_addr[ADDR_W-1:2],2'b00}
- hwdata  out  32  constant 0
- hrdata  in  32  slave read data (icache rdata)
- hready  in  1  slave ready (icache hready_out)

## Operation
- All AHB outputs registered. Reset: hsel=0, htrans=0, haddr=0, hsize=3'h2, hburst=0, hwrite=0, hwdata=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0; FIFO empty, all flags cleared.
- State: addr_pend (NONSEQ on bus, not yet accepted), data_pend (+ discard bit), FIFO count cnt.
- req_ready = !flush && (!addr_pend || hready) && (addr_pend + data_pend + cnt < RSP_DEPTH). Pop in same cycle earns no credit.
- Request accept: next cycle hsel=1, htrans=NONSEQ, haddr=aligned req_addr, addr_pend=1.
- Edge with addr_pend && hready: address accepted → data_pend=1; if no new request accepted that edge, hsel=0, htrans=IDLE, haddr=0.
- Edge with data_pend && hready: hrdata pushed to FIFO (unless discard set); data_pend cleared unless a new address is accepted same edge.
- While hready=0 all address-phase outputs held stable; no new request accepted.
- hready ignored when neither flag set.
- Flush edge: FIFO cleared (cnt=0, rsp_valid=0); data_pend transfer marked discard; an un-accepted addr_pend stays on bus until accepted (AHB forbids withdrawal), then its data also discarded. Flush with pop same edge: flush wins.
- Simultaneous push and pop: cnt unchanged, order preserved.
- Responses returned strictly in request order.

## Timing
- Zero-wait slave: request accepted edge E0; NONSEQ visible E0+; address accepted E1; data captured E2; rsp_valid high after E2 (latency 2 edges).
- N wait states in data phase add N edges; wait states in address phase (hready low from previous data phase) stall equally.
- Throughput: one fetch per cycle with zero-wait slave, rsp_ready=1, RSP_DEPTH≥4.
- Async reset mid-transfer: outputs to reset values immediately; in-flight data lost; icache is reset on the same net.

## Test plan
- Single fetch 0x00020, zero-wait model → haddr=0x00020 htrans=2 one cycle, rsp_valid 2 edges after accept with data=mem[0x20].
- icache miss: fetch 0x00030, hready low 40 cycles → haddr/htrans held all 40 cycles, req_ready=0, single response with mem[0x30].
- Back-to-back 0x20,0x24,0x30,0x34,0x20,0x24, zero-wait, rsp_ready=1 → six consecutive NONSEQ cycles, responses in order, no gaps.
- rsp_ready=0, issue 6 requests → exactly 4 transfers on bus, req_ready=0 thereafter; release rsp_ready → remaining 2 issued, all 6 in order.
- Flush while one address pending (hready=0) and one in data phase → both completions discarded, rsp_valid stays 0, next fetch 0x24 returns only mem[0x24].
- Unaligned req_addr 0x00023 → haddr=0x00020; reset asserted mid data phase → all outputs reset values same cycle, busy=0.
